// File: rtl/cpu86_exec_vld_writer.sv
// Execute-stage retirement recorder: one outstanding instruction,
// shadow register file, write-through record to the validation monitor.
module cpu86_exec_vld_writer #(
  parameter logic [15:0] FL_RESET = 16'h0002
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [4:0]  instr_op,
  input  logic [3:0]  instr_code,
  input  logic [15:0] instr_cs,
  input  logic [15:0] instr_ip,
  input  logic [3:0]  instr_sreg,
  input  logic [3:0]  instr_dreg,
  input  logic        instr_branch_taken,
  input  logic        wr_valid,
  input  logic [3:0]  wr_reg,
  input  logic [15:0] wr_data,
  input  logic        sp_wr_valid,
  input  logic [15:0] sp_wr_data,
  input  logic        fl_wr_valid,
  input  logic [15:0] fl_wr_data,
  input  logic        instr_done,
  input  logic        flush,
  output logic        vld_valid,
  output logic [4:0]  vld_op,
  output logic [3:0]  vld_code,
  output logic [15:0] vld_cs,
  output logic [15:0] vld_ip,
  output logic [15:0] vld_ax,
  output logic [15:0] vld_bx,
  output logic [15:0] vld_cx,
  output logic [15:0] vld_dx,
  output logic [15:0] vld_bp,
  output logic [15:0] vld_sp,
  output logic [15:0] vld_si,
  output logic [15:0] vld_di,
  output logic [15:0] vld_fl,
  output logic [3:0]  vld_sreg,
  output logic [3:0]  vld_dreg,
  output logic        vld_branch_taken
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t      state;
  logic [15:0] ax, bx, cx, dx, bp, sp, si, di, fl;
  logic [15:0] nx_ax, nx_bx, nx_cx, nx_dx;
  logic [15:0] nx_bp, nx_sp, nx_si, nx_di, nx_fl;
  logic [15:0] wr_hit;
  logic [4:0]  l_op;
  logic [3:0]  l_code, l_sreg, l_dreg;
  logic [15:0] l_cs, l_ip;
  logic        l_bt;

  assign instr_ready = resetn && (state == IDLE);

  // Decode the write ports into next shadow values (segment ids ignored)
  always_comb begin
    wr_hit = '0;
    if (wr_valid)
      wr_hit[wr_reg] = 1'b1;
    nx_ax = wr_hit[0] ? wr_data : ax;
    nx_dx = wr_hit[1] ? wr_data : dx;
    nx_cx = wr_hit[2] ? wr_data : cx;
    nx_bx = wr_hit[3] ? wr_data : bx;
    nx_bp = wr_hit[4] ? wr_data : bp;
    nx_si = wr_hit[5] ? wr_data : si;
    nx_di = wr_hit[6] ? wr_data : di;
    nx_sp = wr_hit[7] ? wr_data
          : sp_wr_valid ? sp_wr_data : sp;
    nx_fl = fl_wr_valid ? fl_wr_data
          : wr_hit[12] ? wr_data : fl;
  end

  // Shadow register file, updated regardless of FSM state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ax <= '0; bx <= '0; cx <= '0; dx <= '0;
      bp <= '0; sp <= '0; si <= '0; di <= '0;
      fl <= FL_RESET;
    end else begin
      ax <= nx_ax; bx <= nx_bx; cx <= nx_cx; dx <= nx_dx;
      bp <= nx_bp; sp <= nx_sp; si <= nx_si; di <= nx_di;
      fl <= nx_fl;
    end
  end

  // Accept/retire FSM; record captures same-cycle writes
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      vld_valid <= 1'b0;
      l_op <= '0; l_code <= '0; l_cs <= '0; l_ip <= '0;
      l_sreg <= '0; l_dreg <= '0; l_bt <= 1'b0;
      vld_op <= '0; vld_code <= '0;
      vld_cs <= '0; vld_ip <= '0;
      vld_ax <= '0; vld_bx <= '0; vld_cx <= '0; vld_dx <= '0;
      vld_bp <= '0; vld_sp <= '0; vld_si <= '0; vld_di <= '0;
      vld_fl <= '0;
      vld_sreg <= '0; vld_dreg <= '0;
      vld_branch_taken <= 1'b0;
    end else begin
      vld_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (instr_valid) begin
            l_op <= instr_op;
            l_code <= instr_code;
            l_cs <= instr_cs;
            l_ip <= instr_ip;
            l_sreg <= instr_sreg;
            l_dreg <= instr_dreg;
            l_bt <= instr_branch_taken;
            state <= PEND;
          end
        end
        PEND: begin
          if (flush) begin
            state <= IDLE;
          end else if (instr_done) begin
            state <= IDLE;
            vld_valid <= 1'b1;
            vld_op <= l_op;
            vld_code <= l_code;
            vld_cs <= l_cs;
            vld_ip <= l_ip;
            vld_sreg <= l_sreg;
            vld_dreg <= l_dreg;
            vld_branch_taken <= l_bt;
            vld_ax <= nx_ax; vld_bx <= nx_bx;
            vld_cx <= nx_cx; vld_dx <= nx_dx;
            vld_bp <= nx_bp; vld_sp <= nx_sp;
            vld_si <= nx_si; vld_di <= nx_di;
            vld_fl <= nx_fl;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu86_exec_vld_writer.sv
// Directed bench for cpu86_exec_vld_writer; expected
// records queued at instr_done, checked when vld_valid fires.
module tb_cpu86_exec_vld_writer;

  logic        clk, resetn;
  logic        instr_valid, instr_ready;
  logic [4:0]  instr_op;
  logic [3:0]  instr_code, instr_sreg, instr_dreg;
  logic [15:0] instr_cs, instr_ip;
  logic        instr_branch_taken;
  logic        wr_valid;
  logic [3:0]  wr_reg;
  logic [15:0] wr_data;
  logic        sp_wr_valid, fl_wr_valid;
  logic [15:0] sp_wr_data, fl_wr_data;
  logic        instr_done, flush;
  logic        vld_valid;
  logic [4:0]  vld_op;
  logic [3:0]  vld_code, vld_sreg, vld_dreg;
  logic [15:0] vld_cs, vld_ip, vld_ax, vld_bx, vld_cx, vld_dx;
  logic [15:0] vld_bp, vld_sp, vld_si, vld_di, vld_fl;
  logic        vld_branch_taken;

  typedef struct {
    logic [4:0]  op;
    logic [3:0]  code, sreg, dreg;
    logic [15:0] cs, ip;
    logic        bt;
    logic [15:0] ax, bx, cx, dx, bp, sp, si, di, fl;
  } rec_t;

  rec_t        q[$];
  rec_t        cur, mr;
  logic [15:0] m [0:12];
  int          n_assert = 0;
  int          n_fail = 0;

  cpu86_exec_vld_writer dut (
    .clk(clk), .resetn(resetn),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_code(instr_code),
    .instr_cs(instr_cs), .instr_ip(instr_ip),
    .instr_sreg(instr_sreg), .instr_dreg(instr_dreg),
    .instr_branch_taken(instr_branch_taken),
    .wr_valid(wr_valid), .wr_reg(wr_reg), .wr_data(wr_data),
    .sp_wr_valid(sp_wr_valid), .sp_wr_data(sp_wr_data),
    .fl_wr_valid(fl_wr_valid), .fl_wr_data(fl_wr_data),
    .instr_done(instr_done), .flush(flush),
    .vld_valid(vld_valid), .vld_op(vld_op), .vld_code(vld_code),
    .vld_cs(vld_cs), .vld_ip(vld_ip),
    .vld_ax(vld_ax), .vld_bx(vld_bx), .vld_cx(vld_cx),
    .vld_dx(vld_dx), .vld_bp(vld_bp), .vld_sp(vld_sp),
    .vld_si(vld_si), .vld_di(vld_di), .vld_fl(vld_fl),
    .vld_sreg(vld_sreg), .vld_dreg(vld_dreg),
    .vld_branch_taken(vld_branch_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 13; i++) m[i] = 16'h0000;
    m[12] = 16'h0002;
  endtask

  task automatic accept(input logic [4:0] op,
                        input logic [3:0] code,
                        input logic [15:0] cs,
                        input logic [15:0] ip,
                        input logic [3:0] sr,
                        input logic [3:0] dr,
                        input logic bt);
    instr_valid = 1'b1;
    instr_op = op; instr_code = code;
    instr_cs = cs; instr_ip = ip;
    instr_sreg = sr; instr_dreg = dr;
    instr_branch_taken = bt;
    cur.op = op; cur.code = code; cur.cs = cs; cur.ip = ip;
    cur.sreg = sr; cur.dreg = dr; cur.bt = bt;
  endtask

  task automatic push_cur();
    rec_t r;
    r = cur;
    r.ax = m[0]; r.dx = m[1]; r.cx = m[2]; r.bx = m[3];
    r.bp = m[4]; r.si = m[5]; r.di = m[6]; r.sp = m[7];
    r.fl = m[12];
    q.push_back(r);
  endtask

  task automatic clr_wr();
    wr_valid = 1'b0; sp_wr_valid = 1'b0; fl_wr_valid = 1'b0;
    instr_done = 1'b0; flush = 1'b0;
  endtask

  // Scoreboard: every record must match the oldest queued one
  always @(negedge clk) begin
    if (vld_valid === 1'b1) begin
      n_assert++;
      assert (q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_record got=1 exp=0");
      end
      if (q.size() > 0) begin
        mr = q.pop_front();
        chk("rec_op", {11'd0, vld_op}, {11'd0, mr.op});
        chk("rec_code", {12'd0, vld_code}, {12'd0, mr.code});
        chk("rec_cs", vld_cs, mr.cs);
        chk("rec_ip", vld_ip, mr.ip);
        chk("rec_sreg", {12'd0, vld_sreg}, {12'd0, mr.sreg});
        chk("rec_dreg", {12'd0, vld_dreg}, {12'd0, mr.dreg});
        chk("rec_bt", {15'd0, vld_branch_taken}, {15'd0, mr.bt});
        chk("rec_ax", vld_ax, mr.ax);
        chk("rec_bx", vld_bx, mr.bx);
        chk("rec_cx", vld_cx, mr.cx);
        chk("rec_dx", vld_dx, mr.dx);
        chk("rec_bp", vld_bp, mr.bp);
        chk("rec_sp", vld_sp, mr.sp);
        chk("rec_si", vld_si, mr.si);
        chk("rec_di", vld_di, mr.di);
        chk("rec_fl", vld_fl, mr.fl);
      end
    end
  end

  initial begin
    resetn = 1'b0;
    instr_valid = 1'b0; instr_op = '0; instr_code = '0;
    instr_cs = '0; instr_ip = '0; instr_sreg = '0; instr_dreg = '0;
    instr_branch_taken = 1'b0;
    wr_reg = '0; wr_data = '0; sp_wr_data = '0; fl_wr_data = '0;
    clr_wr();
    m_reset();
    tick();
    tick();
    @(negedge clk);
    chk("rst_ready", {15'd0, instr_ready}, 16'd0);
    chk("rst_valid", {15'd0, vld_valid}, 16'd0);
    chk("rst_ax", vld_ax, 16'h0000);
    chk("rst_fl", vld_fl, 16'h0000);
    chk("rst_cs", vld_cs, 16'h0000);
    chk("rst_ip", vld_ip, 16'h0000);
    resetn = 1'b1;
    tick();
    @(negedge clk);
    chk("ready_after_rst", {15'd0, instr_ready}, 16'd1);
    tick();

    // MOVU, AX write, then done
    accept(5'b00001, 4'h0, 16'hF000, 16'hFFF0, 4'd0, 4'd0, 1'b0);
    tick();
    instr_valid = 1'b0;
    wr_valid = 1'b1; wr_reg = 4'd0; wr_data = 16'h1234;
    m[0] = 16'h1234;
    @(negedge clk);
    chk("busy_ready", {15'd0, instr_ready}, 16'd0);
    tick();
    clr_wr();
    instr_done = 1'b1;
    push_cur();
    tick();
    clr_wr();
    @(negedge clk);
    chk("movu_pulse", {15'd0, vld_valid}, 16'd1);
    tick();
    @(negedge clk);
    chk("one_cycle_pulse", {15'd0, vld_valid}, 16'd0);

    // PUSHR: BX and SP written in the done cycle
    accept(5'b00101, 4'b1000, 16'h1000, 16'h0010, 4'd3, 4'd7, 1'b0);
    tick();
    instr_valid = 1'b0;
    wr_valid = 1'b1; wr_reg = 4'd3; wr_data = 16'h00AA;
    sp_wr_valid = 1'b1; sp_wr_data = 16'hFFFE;
    instr_done = 1'b1;
    m[3] = 16'h00AA; m[7] = 16'hFFFE;
    push_cur();
    tick();
    clr_wr();
    tick();
    @(negedge clk);
    chk("hold_ax", vld_ax, 16'h1234);
    chk("hold_sp", vld_sp, 16'hFFFE);

    // SP and FL port conflicts; segment write ignored
    accept(5'b00011, 4'h2, 16'h2000, 16'h0100, 4'd7, 4'd12, 1'b0);
    tick();
    instr_valid = 1'b0;
    wr_valid = 1'b1; wr_reg = 4'd7; wr_data = 16'h1000;
    sp_wr_valid = 1'b1; sp_wr_data = 16'h2000;
    m[7] = 16'h1000;
    tick();
    clr_wr();
    wr_valid = 1'b1; wr_reg = 4'd12; wr_data = 16'h0000;
    fl_wr_valid = 1'b1; fl_wr_data = 16'h0046;
    instr_done = 1'b1;
    m[12] = 16'h0046;
    push_cur();
    tick();
    clr_wr();
    wr_valid = 1'b1; wr_reg = 4'd9; wr_data = 16'hDEAD;
    tick();
    clr_wr();

    // Taken branch flushed with simultaneous done
    accept(5'b01000, 4'h4, 16'h3000, 16'h0200, 4'd0, 4'd0, 1'b1);
    tick();
    instr_valid = 1'b0;
    wr_valid = 1'b1; wr_reg = 4'd2; wr_data = 16'h5555;
    m[2] = 16'h5555;
    flush = 1'b1; instr_done = 1'b1;
    tick();
    clr_wr();
    @(negedge clk);
    chk("flush_no_rec", {15'd0, vld_valid}, 16'd0);
    chk("flush_ready", {15'd0, instr_ready}, 16'd1);
    accept(5'b01000, 4'h1, 16'h3000, 16'h0204, 4'd5, 4'd6, 1'b1);
    tick();
    instr_valid = 1'b0;
    instr_done = 1'b1;
    push_cur();
    tick();
    clr_wr();
    tick();

    // Back-to-back with source holding the next instruction
    accept(5'b00010, 4'h3, 16'h4000, 16'h0300, 4'd1, 4'd4, 1'b0);
    tick();
    wr_valid = 1'b1; wr_reg = 4'd4; wr_data = 16'hBBBB;
    m[4] = 16'hBBBB;
    instr_done = 1'b1;
    push_cur();
    accept(5'b00110, 4'h5, 16'h4000, 16'h0302, 4'd5, 4'd6, 1'b0);
    tick();
    clr_wr();
    @(negedge clk);
    chk("b2b_ready", {15'd0, instr_ready}, 16'd1);
    tick();
    instr_valid = 1'b0;
    @(negedge clk);
    chk("b2b_busy", {15'd0, instr_ready}, 16'd0);
    wr_valid = 1'b1; wr_reg = 4'd5; wr_data = 16'h0555;
    sp_wr_valid = 1'b1; sp_wr_data = 16'h0FF0;
    wr_reg = 4'd6;
    m[6] = 16'h0555; m[7] = 16'h0FF0;
    instr_done = 1'b1;
    push_cur();
    tick();
    clr_wr();
    tick();

    // Reset while pending discards the instruction
    accept(5'b00111, 4'h6, 16'h5000, 16'h0400, 4'd1, 4'd1, 1'b0);
    tick();
    instr_valid = 1'b0;
    wr_valid = 1'b1; wr_reg = 4'd1; wr_data = 16'h7777;
    resetn = 1'b0;
    instr_done = 1'b1;
    tick();
    wr_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("prst_valid", {15'd0, vld_valid}, 16'd0);
    chk("prst_ready", {15'd0, instr_ready}, 16'd0);
    chk("prst_ax", vld_ax, 16'h0000);
    chk("prst_sp", vld_sp, 16'h0000);
    chk("prst_fl", vld_fl, 16'h0000);
    chk("prst_ip", vld_ip, 16'h0000);
    m_reset();
    instr_done = 1'b0;
    resetn = 1'b1;
    tick();
    @(negedge clk);
    chk("prst_rel_ready", {15'd0, instr_ready}, 16'd1);
    chk("prst_rel_valid", {15'd0, vld_valid}, 16'd0);
    accept(5'b00001, 4'h7, 16'h6000, 16'h0500, 4'd2, 4'd3, 1'b0);
    tick();
    instr_valid = 1'b0;
    instr_done = 1'b1;
    push_cur();
    tick();
    clr_wr();
    tick();
    tick();
    @(negedge clk);
    n_assert++;
    assert (q.size() == 0) else begin
      n_fail++;
      $error("FAIL lost_records got=%0d exp=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
